// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the immediate decode stage.
// Entries carry a 64-bit immediate so one struct serves both XLEN=32 and XLEN=64.
package imm_pkg;

    localparam int unsigned ImmMaxW = 64;

    localparam logic [6:0] OpLoad    = 7'b0000011;
    localparam logic [6:0] OpOpImm   = 7'b0010011;
    localparam logic [6:0] OpOpImm32 = 7'b0011011;
    localparam logic [6:0] OpAuipc   = 7'b0010111;
    localparam logic [6:0] OpStore   = 7'b0100011;
    localparam logic [6:0] OpOp      = 7'b0110011;
    localparam logic [6:0] OpLui     = 7'b0110111;
    localparam logic [6:0] OpOp32    = 7'b0111011;
    localparam logic [6:0] OpBranch  = 7'b1100011;
    localparam logic [6:0] OpJalr    = 7'b1100111;
    localparam logic [6:0] OpJal     = 7'b1101111;
    localparam logic [6:0] OpSystem  = 7'b1110011;

    typedef enum logic [2:0] {
        ImmNone = 3'd0,
        ImmI    = 3'd1,
        ImmS    = 3'd2,
        ImmB    = 3'd3,
        ImmU    = 3'd4,
        ImmJ    = 3'd5
    } imm_type_e;

    typedef struct packed {
        logic [31:0]        inst;
        logic [ImmMaxW-1:0] imm;
        imm_type_e          imm_type;
        logic               illegal;
    } decoded_t;

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational RISC-V immediate decoder: classifies the opcode and assembles the
// sign-extended immediate at XLEN width.
module imm_decode_comb
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     inst_i,
    output logic [XLEN-1:0] imm_o,
    output imm_type_e       type_o,
    output logic            illegal_o
);

    logic [6:0] opcode;
    logic       sgn;

    assign opcode = inst_i[6:0];
    assign sgn    = inst_i[31];

    // Every listed opcode ends in 2'b11, so compressed encodings fall to default.
    always_comb begin
        type_o    = ImmNone;
        illegal_o = 1'b0;
        case (opcode)
            OpLoad, OpOpImm, OpJalr, OpSystem: type_o = ImmI;
            OpOpImm32: begin
                if (XLEN == 64) type_o = ImmI;
                else            illegal_o = 1'b1;
            end
            OpStore:         type_o = ImmS;
            OpBranch:        type_o = ImmB;
            OpAuipc, OpLui:  type_o = ImmU;
            OpJal:           type_o = ImmJ;
            OpOp:            type_o = ImmNone;
            OpOp32: begin
                if (XLEN != 64) illegal_o = 1'b1;
            end
            default:         illegal_o = 1'b1;
        endcase
    end

    always_comb begin
        imm_o = '0;
        case (type_o)
            ImmI: imm_o = {{(XLEN-12){sgn}}, inst_i[31:20]};
            ImmS: imm_o = {{(XLEN-12){sgn}}, inst_i[31:25], inst_i[11:7]};
            ImmB: imm_o = {{(XLEN-13){sgn}}, inst_i[31], inst_i[7], inst_i[30:25],
                           inst_i[11:8], 1'b0};
            ImmU: imm_o = {{(XLEN-32){sgn}}, inst_i[31:12], 12'b0};
            ImmJ: imm_o = {{(XLEN-21){sgn}}, inst_i[31], inst_i[19:12], inst_i[20],
                           inst_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate decode pipeline stage: decoder at the input, two-entry elastic buffer
// (main + skid), synchronous flush and a saturating illegal-instruction counter.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [31:0]      in_inst,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_type,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [XLEN-1:0] dec_imm;
    imm_type_e       dec_type;
    logic            dec_illegal;
    decoded_t        dec_entry;

    decoded_t         main_q, main_d;
    decoded_t         skid_q, skid_d;
    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic accept;
    logic xfer;

    imm_decode_comb #(
        .XLEN(XLEN)
    ) u_dec (
        .inst_i   (in_inst),
        .imm_o    (dec_imm),
        .type_o   (dec_type),
        .illegal_o(dec_illegal)
    );

    always_comb begin
        dec_entry          = '0;
        dec_entry.inst     = in_inst;
        dec_entry.imm      = ImmMaxW'($signed(dec_imm));
        dec_entry.imm_type = dec_type;
        dec_entry.illegal  = dec_illegal;
    end

    // in_ready comes straight from the skid flag, so out_ready never reaches it.
    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready;
    assign xfer     = main_valid_q && out_ready;

    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        cnt_d        = cnt_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (accept && dec_entry.illegal && (cnt_q != CntMax)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (!main_valid_q || xfer) begin
                if (skid_valid_q) begin
                    main_d       = skid_q;
                    main_valid_d = 1'b1;
                    skid_valid_d = 1'b0;
                end else begin
                    main_valid_d = accept;
                    if (accept) main_d = dec_entry;
                end
            end else if (accept) begin
                skid_d       = dec_entry;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out_valid   = main_valid_q;
    assign out_inst    = main_q.inst;
    assign out_imm     = main_q.imm[XLEN-1:0];
    assign out_type    = main_q.imm_type;
    assign out_illegal = main_q.illegal;
    assign illegal_cnt = cnt_q;

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Pipelined, XLEN-parametrised immediate decode stage for the RV32I/RV64I core. It accepts one instruction per cycle over a valid/ready handshake and produces, one cycle later, the sign-extended immediate, its format class and an illegal-opcode flag. A two-entry elastic buffer gives full throughput under back-pressure. It also supports pipeline flush and keeps a saturating illegal-instruction counter. It sits between fetch and the register-read/execute stage.

## Interface
- XLEN, 32: datapath width, legal values 32 or 64; the immediate is sign-extended to XLEN.
- CNT_W, 16: width of the illegal-instruction counter.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous discard of all buffered entries.
- in_valid  in  1  instruction present.
- in_inst  in  32  raw instruction word.
- in_ready  out  1  stage can accept; registered.
- out_valid  out  1  decoded entry present.
- out_ready  in  1  consumer accepts.
- out_inst  out  32  instruction passed through with its decode.
- out_imm  out  XLEN  decoded immediate.
- out_type  out  3  format class: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.
- out_illegal  out  1  opcode not recognised.
- illegal_cnt  out  CNT_W  count of illegal instructions accepted; saturating.

## Operation
- Opcode map, using inst[6:0]:
  - I-type: 0000011, 0010011, 1100111, 1110011; plus 0011011 when XLEN=64.
  - S-type: 0100011.
  - B-type: 1100011.
  - U-type: 0010111, 0110111.
  - J-type: 1101111.
  - NONE and legal: 0110011; plus 0111011 when XLEN=64.
- Any other opcode, or inst[1:0] != 2'b11:
  - out_imm = 0, out_type = NONE, out_illegal = 1.
- Immediate bit assembly follows the RISC-V base formats.
  - B and J immediates have bit 0 = 0.
  - U-type is {inst[31:12], 12'b0}.
  - All formats are sign-extended from inst[31] to XLEN, including U-type when XLEN=64.
- Buffer: a main register drives the outputs; a skid register catches one entry while the output is stalled.
  - Decode is performed on entry into either register.
  - Output order always matches input order.
- Accept condition: in_valid && in_ready. Output transfer condition: out_valid && out_ready.
- While out_valid && !out_ready, all out_* fields are held stable.
- illegal_cnt increments by 1 on every accepted illegal instruction and saturates at 2^CNT_W-1.
  - The counter is not cleared by flush.

## Timing
- Latency: an instruction accepted in cycle N appears on out_* in cycle N+1 when the main register is empty or draining.
- Throughput: 1 per cycle while out_ready = 1.
- in_ready = !skid_valid, driven from a register; there is no combinational path from out_ready to in_ready.
- Simultaneous accept and transfer with skid empty: the new entry goes straight to the main register.
- Main register stalled and an accept occurs: the entry goes to skid, and in_ready = 0 from the next cycle.
- Transfer with skid full: skid moves to main, and in_ready = 1 the next cycle.
- flush has highest priority:
  - The next cycle has out_valid = 0 and in_ready = 1.
  - An input presented in the flush cycle is discarded and is not counted.
- Reset values:
  - out_valid 0, in_ready 1.
  - out_inst 0, out_imm 0, out_type 0 (NONE), out_illegal 0.
  - illegal_cnt 0.
- Reset asserted mid-transfer drops all entries immediately and asynchronously.

## Structure
- The shared package imm_pkg holds:
  - the opcode localparams;
  - the imm_type_e enum (NONE/I/S/B/U/J, 3 bits);
  - a decoded-entry struct {inst, imm, type, illegal}.
- Sub-module imm_decode_comb: purely combinational XLEN-parametrised decoder (inst -> imm, type, illegal). It is instantiated once at the input of imm_decode_stage.
- imm_decode_stage contains only the elastic buffer, the flush logic and the counter.

## Test plan
- XLEN=32, in 0xFFF00093 (addi x1,x0,-1) with out_ready = 1 -> next cycle out_imm 0xFFFFFFFF, type I, illegal 0.
- XLEN=32, in 0xFE000EE3 (beq -4) -> out_imm 0xFFFFFFFC, type B; XLEN=64, in 0x800000B7 (lui) -> out_imm 0xFFFFFFFF80000000, type U.
- Back-pressure: three back-to-back valid instructions, out_ready held 0 for 3 cycles:
  - first held stable on outputs, second in skid, in_ready = 0, third stalled;
  - after release, all three emerge in order, one per cycle.
- Flush with both registers full and in_valid = 1 -> next cycle out_valid 0, in_ready 1; illegal_cnt unchanged.
- In 0x00000000 -> out_illegal 1, out_imm 0, type NONE, illegal_cnt +1. With CNT_W=2, five illegal instructions -> illegal_cnt stays at 3.
- Async rst asserted mid-stall -> all outputs at their reset values immediately; stream restarts cleanly after deassert.
